udp_rx_port_buffer: RTL

Store-and-forward receive buffer for one UDP port. Sits directly downstream of the UDP protocol stage and consumes its `UDPv4RxBus`. Accepts only datagrams addressed to `PORT` and holds each one until the upstream `commit`; rolls back partial data on `drop`. Releases complete, checksum-verified payloads to the application over a valid/ready stream, with per-packet metadata.

---
 rtl/udp_rx_port_buffer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/udp_rx_port_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_rx_port_buffer: store-and-forward receive buffer for one UDP port.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

package udp_pkg;
  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        drop;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] payload_len;
    logic [31:0] src_ip;
  } UDPv4RxBus;
endpackage

module udp_rx_port_buffer
  import udp_pkg::*;
#(
  parameter logic [15:0] PORT       = 16'd0,
  parameter int          DEPTH      = 512,
  parameter int          META_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  UDPv4RxBus   rx_l4_bus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes_valid,
  output logic [31:0] out_src_ip,
  output logic [15:0] out_src_port,
  output logic [15:0] out_len,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic [31:0] overflow_count
);
  localparam int          AW        = $clog2(DEPTH);
  localparam int          MW        = $clog2(META_DEPTH);
  localparam logic [16:0] DEPTH_W   = 17'(DEPTH);
  localparam logic [MW:0] META_FULL = (MW+1)'(META_DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [MW:0] MPTR_ONE  = (MW+1)'(1);

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ACCEPT = 2'd1, WR_DISCARD = 2'd2} wr_state_t;
  typedef enum logic [0:0] {OUT_IDLE = 1'b0, OUT_BODY = 1'b1} rd_state_t;

  logic [31:0] mem      [DEPTH];
  logic [63:0] meta_mem [META_DEPTH];

  wr_state_t   r_wr_state;
  rd_state_t   r_rd_state;
  logic [AW:0] r_wr_ptr, r_wr_tmp, r_rd_ptr;
  logic [AW-1:0] r_raddr;
  logic [MW:0] r_meta_wptr, r_meta_rptr;
  logic [14:0] r_need, r_wcnt, r_words_left, r_issue_left;
  logic [31:0] r_lat_ip, r_rdata, r_skid;
  logic [15:0] r_lat_port, r_lat_len;
  logic        r_rvalid, r_skid_valid, r_first;

  logic [14:0] w_need, w_pop_need;
  logic [AW:0] w_used;
  logic [16:0] w_free;
  logic [63:0] w_meta_head;
  logic [1:0]  w_occ;
  logic        w_meta_full, w_meta_empty, w_port_ok, w_len_ok, w_fit;
  logic        w_in_acc, w_excess, w_we, w_push, w_xfer, w_pop, w_issue, w_unused;

  // Space is judged against the published pointer; any partial write is rolled back first.
  assign w_need       = 15'((17'(rx_l4_bus.payload_len) + 17'd3) >> 2);
  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign w_free       = DEPTH_W - 17'(w_used);
  assign w_meta_full  = (r_meta_wptr - r_meta_rptr) == META_FULL;
  assign w_meta_empty = r_meta_wptr == r_meta_rptr;
  assign w_port_ok    = rx_l4_bus.dst_port == PORT;
  assign w_len_ok     = rx_l4_bus.payload_len != 16'd0;
  assign w_fit        = (17'(w_need) <= w_free) && !w_meta_full;
  assign w_in_acc     = (r_wr_state == WR_ACCEPT) && !rx_l4_bus.start && !rx_l4_bus.drop;
  assign w_excess     = r_wcnt == r_need;
  assign w_we         = w_in_acc && rx_l4_bus.data_valid && !w_excess;
  assign w_push       = w_in_acc && rx_l4_bus.commit && !(rx_l4_bus.data_valid && w_excess);
  assign w_unused     = ^rx_l4_bus.bytes_valid;

  always_ff @(posedge clk) begin
    if (w_we) mem[r_wr_tmp[AW-1:0]] <= rx_l4_bus.data;
    if (w_push) meta_mem[r_meta_wptr[MW-1:0]] <= {r_lat_ip, r_lat_port, r_lat_len};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state     <= WR_IDLE;
      r_wr_ptr       <= '0;
      r_wr_tmp       <= '0;
      r_meta_wptr    <= '0;
      r_need         <= '0;
      r_wcnt         <= '0;
      r_lat_ip       <= '0;
      r_lat_port     <= '0;
      r_lat_len      <= '0;
      pkt_count      <= '0;
      drop_count     <= '0;
      overflow_count <= '0;
    end else begin
      case (r_wr_state)
        WR_ACCEPT: begin
          if (rx_l4_bus.start || rx_l4_bus.drop || (rx_l4_bus.data_valid && w_excess)) begin
            r_wr_tmp   <= r_wr_ptr;
            drop_count <= drop_count + 32'd1;
            r_wr_state <= rx_l4_bus.drop ? WR_IDLE : WR_DISCARD;
          end else begin
            if (rx_l4_bus.data_valid) begin
              r_wr_tmp <= r_wr_tmp + PTR_ONE;
              r_wcnt   <= r_wcnt + 15'd1;
            end
            if (rx_l4_bus.commit) begin
              r_wr_ptr    <= rx_l4_bus.data_valid ? r_wr_tmp + PTR_ONE : r_wr_tmp;
              r_meta_wptr <= r_meta_wptr + MPTR_ONE;
              pkt_count   <= pkt_count + 32'd1;
              r_wr_state  <= WR_IDLE;
            end
          end
        end
        WR_DISCARD: if (rx_l4_bus.commit || rx_l4_bus.drop) r_wr_state <= WR_IDLE;
        default: ;
      endcase
      // A new start always wins, including the one that aborts an open packet.
      if (rx_l4_bus.start) begin
        if (w_port_ok && w_len_ok && w_fit) begin
          r_wr_state <= WR_ACCEPT;
          r_need     <= w_need;
          r_wcnt     <= '0;
          r_lat_ip   <= rx_l4_bus.src_ip;
          r_lat_port <= rx_l4_bus.src_port;
          r_lat_len  <= rx_l4_bus.payload_len;
        end else begin
          r_wr_state <= WR_DISCARD;
          if (w_port_ok && w_len_ok) overflow_count <= overflow_count + 32'd1;
        end
      end
    end
  end

  assign w_meta_head     = meta_mem[r_meta_rptr[MW-1:0]];
  assign w_pop_need      = 15'((17'(w_meta_head[15:0]) + 17'd3) >> 2);
  assign w_xfer          = out_valid && out_ready;
  assign out_sop         = out_valid && r_first;
  assign out_eop         = out_valid && (r_words_left == 15'd1);
  assign out_bytes_valid = !out_valid ? 3'd0 :
                           (out_eop && out_len[1:0] != 2'd0) ? {1'b0, out_len[1:0]} : 3'd4;
  assign w_pop           = !w_meta_empty && ((r_rd_state == OUT_IDLE) || (w_xfer && out_eop));
  assign w_occ           = {1'b0, out_valid} + {1'b0, r_skid_valid} + {1'b0, r_rvalid};
  // Output register plus skid hold two words, so a read is issued only when one of them is free.
  assign w_issue         = (r_rd_state == OUT_BODY) && (r_issue_left != 15'd0) &&
                           ((w_occ - {1'b0, w_xfer}) < 2'd2);

  always_ff @(posedge clk) begin
    if (w_issue) r_rdata <= mem[r_raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state   <= OUT_IDLE;
      r_rd_ptr     <= '0;
      r_raddr      <= '0;
      r_meta_rptr  <= '0;
      r_words_left <= '0;
      r_issue_left <= '0;
      r_rvalid     <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_first      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_src_ip   <= '0;
      out_src_port <= '0;
      out_len      <= '0;
    end else begin
      r_rvalid <= w_issue;
      if (w_issue) begin
        r_raddr      <= r_raddr + 1'b1;
        r_issue_left <= r_issue_left - 15'd1;
      end
      if (w_xfer) begin
        r_rd_ptr     <= r_rd_ptr + PTR_ONE;
        r_words_left <= r_words_left - 15'd1;
        r_first      <= 1'b0;
      end
      if (!out_valid || w_xfer) begin
        if (r_skid_valid) begin
          out_data     <= r_skid;
          out_valid    <= 1'b1;
          r_skid_valid <= r_rvalid;
          r_skid       <= r_rdata;
        end else begin
          out_valid <= r_rvalid;
          if (r_rvalid) out_data <= r_rdata;
        end
      end else if (r_rvalid) begin
        r_skid       <= r_rdata;
        r_skid_valid <= 1'b1;
      end
      if (w_pop) begin
        r_rd_state                           <= OUT_BODY;
        {out_src_ip, out_src_port, out_len}  <= w_meta_head;
        r_words_left                         <= w_pop_need;
        r_issue_left                         <= w_pop_need;
        r_first                              <= 1'b1;
        r_meta_rptr                          <= r_meta_rptr + MPTR_ONE;
      end else if (w_xfer && out_eop) begin
        r_rd_state <= OUT_IDLE;
      end
    end
  end
endmodule
`default_nettype wire
